tp_col_serializer: RTL and testbench

Consumer end of the transpose stage in the JPEG datapath. Accepts the 8-beat burst of packed column words that the transpose memory emits (one 8-lane word per cycle while its enable is high) and streams them out one BW-bit sample per beat under a valid/ready handshake. Two-bank ping-pong buffering lets one block drain while the next burst fills. Feeds the downstream per-sample stage (quantizer / zig-zag) that cannot take 8 lanes per cycle.

---
 rtl/tp_col_serializer.sv | 112 +++++++++++
 tb/tb_tp_col_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_col_serializer.sv
// tp_col_serializer: two-bank ping-pong buffer that turns 8-lane column bursts into a BW-bit sample stream.
// Optional macro TP_SER_LSB_FIRST_EN: emit lane 7 (bits [BW-1:0]) first within each word.
module tp_col_serializer #(
  parameter int BW = 8
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [8*BW-1:0] i_data,
  input  logic            i_enable,
  output logic [BW-1:0]   o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_last,
  output logic            o_overflow
);

  logic [8*BW-1:0] mem_words [16];
  logic [1:0]      full_reg, full_next;
  logic            wr_bank_reg;
  logic [2:0]      wr_idx_reg;
  logic            drop_reg;
  logic            rd_bank_reg;
  logic [2:0]      rd_word_reg, rd_samp_reg;
  logic            overflow_reg;

  logic            transfer, block_done, bank_freeing;
  logic            drop_now, write_en, burst_done;
  logic [8*BW-1:0] rd_word_data;
  logic [BW-1:0]   lane [8];
  logic [2:0]      lane_sel;

  assign o_valid      = full_reg[rd_bank_reg];
  assign transfer     = o_valid && i_ready;
  assign block_done   = transfer && (rd_word_reg == 3'd7) && (rd_samp_reg == 3'd7);
  assign bank_freeing = block_done && (rd_bank_reg == wr_bank_reg);

  // A burst is judged once, on its first beat; a bank emptying on that same edge counts as free.
  assign drop_now   = (wr_idx_reg == 3'd0) ? (full_reg[wr_bank_reg] && !bank_freeing) : drop_reg;
  assign write_en   = i_enable && !drop_now;
  assign burst_done = write_en && (wr_idx_reg == 3'd7);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_word
      localparam int B = gi / 8;
      localparam int W = gi % 8;
      logic [8*BW-1:0] word_reg;
      always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset)
          word_reg <= '0;
        else if (write_en && (wr_bank_reg == 1'(B)) && (wr_idx_reg == 3'(W)))
          word_reg <= i_data;
      end
      assign mem_words[gi] = word_reg;
    end
  endgenerate

  assign rd_word_data = mem_words[{rd_bank_reg, rd_word_reg}];

  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign lane[gi] = rd_word_data[(7-gi)*BW +: BW];
    end
  endgenerate

`ifdef TP_SER_LSB_FIRST_EN
  assign lane_sel = ~rd_samp_reg;
`else
  assign lane_sel = rd_samp_reg;
`endif

  assign o_data     = o_valid ? lane[lane_sel] : '0;
  assign o_last     = o_valid && (rd_word_reg == 3'd7) && (rd_samp_reg == 3'd7);
  assign o_overflow = overflow_reg;

  always_comb begin
    full_next = full_reg;
    if (block_done) full_next[rd_bank_reg] = 1'b0;
    if (burst_done) full_next[wr_bank_reg] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      full_reg     <= '0;
      wr_bank_reg  <= 1'b0;
      wr_idx_reg   <= '0;
      drop_reg     <= 1'b0;
      rd_bank_reg  <= 1'b0;
      rd_word_reg  <= '0;
      rd_samp_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
      if (i_enable) begin
        wr_idx_reg <= wr_idx_reg + 3'd1;
        if (wr_idx_reg == 3'd0) begin
          drop_reg <= drop_now;
          if (drop_now) overflow_reg <= 1'b1;
        end
        if (burst_done) wr_bank_reg <= ~wr_bank_reg;
      end
      if (transfer) begin
        rd_samp_reg <= rd_samp_reg + 3'd1;
        if (rd_samp_reg == 3'd7) begin
          rd_word_reg <= rd_word_reg + 3'd1;
          if (rd_word_reg == 3'd7) rd_bank_reg <= ~rd_bank_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_tp_col_serializer.sv
// Randomized and directed bench for tp_col_serializer against a queue-based sample-order model.
module tb_tp_col_serializer;
  localparam int BW = 8;

  logic          i_clk = 1'b0;
  logic          i_Reset = 1'b0;
  logic [63:0]   i_data = '0;
  logic          i_enable = 1'b0;
  logic          i_ready = 1'b0;
  logic [BW-1:0] o_data;
  logic          o_valid, o_last, o_overflow;

  int checks = 0;
  int errors = 0;

  // Model: queue of samples still to be emitted, in output order (resident blocks only).
  int          exp_q[$];
  int          bw_idx = 0;
  bit          bw_drop = 1'b0;
  logic [63:0] bw_words [8];
  bit          ovf = 1'b0;

  always #5 i_clk = ~i_clk;

  tp_col_serializer #(.BW(BW)) dut (
    .i_clk(i_clk), .i_Reset(i_Reset), .i_data(i_data), .i_enable(i_enable),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_overflow(o_overflow)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] make_word(input int base, input int j);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[(7-i)*8 +: 8] = 8'(base + 8*j + i);
    return w;
  endfunction

  function automatic void push_block();
    int lane;
    for (int j = 0; j < 8; j++)
      for (int s = 0; s < 8; s++) begin
`ifdef TP_SER_LSB_FIRST_EN
        lane = 7 - s;
`else
        lane = s;
`endif
        exp_q.push_back(int'(bw_words[j][(7-lane)*8 +: 8]));
      end
  endfunction

  // Drive one cycle from a negedge, advance the model over the posedge, return at the next negedge.
  task automatic step(input logic en, input logic [63:0] d, input logic rdy);
    bit xfer, freeing, start_drop;
    i_enable = en; i_data = d; i_ready = rdy;
    xfer       = (exp_q.size() > 0) && rdy;
    freeing    = xfer && (exp_q.size() % 64 == 1);
    start_drop = (exp_q.size() > 64) && !freeing;
    @(posedge i_clk);
    if (xfer) void'(exp_q.pop_front());
    if (en) begin
      if (bw_idx == 0) begin
        bw_drop = start_drop;
        if (start_drop) ovf = 1'b1;
      end
      if (!bw_drop) begin
        bw_words[bw_idx] = d;
        if (bw_idx == 7) push_block();
      end
      bw_idx = (bw_idx + 1) % 8;
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    repeat (2) @(negedge i_clk);
    checks += 4;
    if (o_valid !== 1'b0)    begin errors++; $display("FAIL reset o_valid got %b exp 0", o_valid); end
    if (o_data !== '0)       begin errors++; $display("FAIL reset o_data got %0d exp 0", o_data); end
    if (o_last !== 1'b0)     begin errors++; $display("FAIL reset o_last got %b exp 0", o_last); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset o_overflow got %b exp 0", o_overflow); end
    i_Reset = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_release o_valid got %b exp 0", o_valid); end
    $display("test_reset done");
  endtask

  task automatic test_single_block();
    int ev, first_valid;
    first_valid = -1;
    for (int c = 0; c < 74; c++) begin
      if (c < 8) step(1'b1, make_word(0, c), 1'b1);
      else       step(1'b0, '0, 1'b1);
      if (o_valid === 1'b1 && first_valid < 0) first_valid = c;
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL single o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL single o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL single o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== ovf) begin errors++; $display("FAIL single o_overflow got %b exp %b", o_overflow, ovf); end
    end
    checks++;
    if (first_valid != 7) begin errors++; $display("FAIL single_latency first valid after beat %0d exp 7", first_valid + 1); end
    $display("test_single_block done first_valid=%0d", first_valid);
  endtask

  task automatic test_backpressure();
    int ev, valid_cycles;
    valid_cycles = 0;
    for (int c = 0; c < 8; c++) step(1'b1, make_word(0, c), 1'b0);
    for (int c = 0; c < 200 && (c == 0 || exp_q.size() > 0 || o_valid === 1'b1); c++) begin
      if (c > 0) step(1'b0, '0, 1'((c - 1) % 2 == 0));
      if (o_valid === 1'b1) valid_cycles++;
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL backpressure o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL backpressure o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL backpressure o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== ovf) begin errors++; $display("FAIL backpressure o_overflow got %b exp %b", o_overflow, ovf); end
    end
    checks++;
    if (valid_cycles < 127 || valid_cycles > 128) begin errors++; $display("FAIL backpressure_drain valid cycles %0d exp 127..128", valid_cycles); end
    $display("test_backpressure done valid_cycles=%0d", valid_cycles);
  endtask

  task automatic test_ping_pong();
    int ev, xfers;
    xfers = 0;
    for (int c = 0; c < 160; c++) begin
      if (o_valid === 1'b1 && c > 0) xfers++;
      if (c < 16) step(1'b1, make_word((c < 8) ? 0 : 100, c % 8), 1'b1);
      else        step(1'b0, '0, 1'b1);
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL pingpong o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL pingpong o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL pingpong o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL pingpong o_overflow got %b exp 0", o_overflow); end
    end
    checks++;
    if (xfers != 128) begin errors++; $display("FAIL pingpong_count transfers %0d exp 128", xfers); end
    $display("test_ping_pong done transfers=%0d", xfers);
  endtask

  task automatic test_collision();
    int ev, cbeats;
    bit hit;
    cbeats = 0; hit = 1'b0;
    for (int c = 0; c < 16; c++) step(1'b1, make_word((c < 8) ? 0 : 64, c % 8), 1'b0);
    for (int c = 0; c < 300 && (exp_q.size() > 0 || (cbeats > 0 && cbeats < 8)); c++) begin
      if (exp_q.size() == 65 && cbeats == 0) begin
        hit = 1'b1;
        step(1'b1, make_word(50, 0), 1'b1);
        cbeats = 1;
      end else if (cbeats > 0 && cbeats < 8) begin
        step(1'b1, make_word(50, cbeats), 1'b1);
        cbeats++;
      end else begin
        step(1'b0, '0, 1'b1);
      end
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL collision o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL collision o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL collision o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL collision o_overflow got %b exp 0", o_overflow); end
    end
    checks++;
    if (!hit || cbeats != 8) begin errors++; $display("FAIL collision_setup hit %0b beats %0d exp 1 8", hit, cbeats); end
    $display("test_collision done");
  endtask

  task automatic test_overflow();
    int ev, xfers;
    xfers = 0;
    for (int c = 0; c < 24; c++) step(1'b1, make_word(64 * (c / 8), c % 8), 1'b0);
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b exp 1", o_overflow); end
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      if (o_valid === 1'b1) xfers++;
      step(1'b0, '0, 1'b1);
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL overflow o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL overflow o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL overflow o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", o_overflow); end
    end
    checks++;
    if (xfers != 128) begin errors++; $display("FAIL overflow_count transfers %0d exp 128", xfers); end
    $display("test_overflow done transfers=%0d", xfers);
  endtask

  task automatic test_async_reset();
    int ev;
    for (int c = 0; c < 8; c++) step(1'b1, make_word(0, c), 1'b1);
    for (int c = 0; c < 20; c++) step(1'(c < 3), make_word(64, c), 1'b1);
    #2 i_Reset = 1'b0;
    #1;
    checks += 4;
    if (o_valid !== 1'b0)    begin errors++; $display("FAIL async_reset o_valid got %b exp 0", o_valid); end
    if (o_data !== '0)       begin errors++; $display("FAIL async_reset o_data got %0d exp 0", o_data); end
    if (o_last !== 1'b0)     begin errors++; $display("FAIL async_reset o_last got %b exp 0", o_last); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL async_reset o_overflow got %b exp 0", o_overflow); end
    exp_q.delete(); bw_idx = 0; bw_drop = 1'b0; ovf = 1'b0;
    @(negedge i_clk);
    i_Reset = 1'b1;
    for (int c = 0; c < 74; c++) begin
      if (c < 8) step(1'b1, make_word(7, c), 1'b1);
      else       step(1'b0, '0, 1'b1);
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL after_reset o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL after_reset o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL after_reset o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== ovf) begin errors++; $display("FAIL after_reset o_overflow got %b exp %b", o_overflow, ovf); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int ev;
    for (int c = 0; c < 1100 && (c < 800 || exp_q.size() > 0); c++) begin
      if (c < 800) step(1'($urandom_range(3) != 0), {$urandom, $urandom}, 1'($urandom_range(2) != 0));
      else         step(1'b0, '0, 1'b1);
      checks += 4;
      ev = (exp_q.size() > 0) ? exp_q[0] : 0;
      if (o_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL random o_valid got %b exp %b c=%0d", o_valid, exp_q.size() > 0, c); end
      if (o_data !== 8'(ev)) begin errors++; $display("FAIL random o_data got %0d exp %0d c=%0d", o_data, ev, c); end
      if (o_last !== (exp_q.size() % 64 == 1)) begin errors++; $display("FAIL random o_last got %b c=%0d", o_last, c); end
      if (o_overflow !== ovf) begin errors++; $display("FAIL random o_overflow got %b exp %b c=%0d", o_overflow, ovf, c); end
    end
    $display("test_random done overflow=%0b", ovf);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_backpressure();
    test_ping_pong();
    test_collision();
    test_overflow();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
